// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add unsigned multiplier that issues one add per cycle to an external shared ALU.
// The ALU carry-out is shifted into hi[WIDTH-1], so the 2*WIDTH-bit product is exact.
module alu_mul_seq #(
  parameter int          WIDTH        = 32,
  parameter logic [3:0]  ALU_CTRL_ADD = 4'b0010
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o,
  output logic [WIDTH-1:0]     alu_src1_o,
  output logic [WIDTH-1:0]     alu_src2_o,
  output logic [3:0]           alu_ctrl_o,
  input  logic [WIDTH-1:0]     alu_result_i,
  input  logic                 alu_cout_i
);
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     mcand_q, hi_q, lo_q;
  logic                 busy_q, done_q;
  logic [2*WIDTH-1:0]   prod_q, acc_d;
  logic                 accept;
  assign accept = start_i && (state_q != RUN);
  assign acc_d  = {alu_cout_i, alu_result_i, lo_q[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      prod_q  <= '0;
    end else if (accept) begin
      state_q <= RUN;
      cnt_q   <= '0;
      mcand_q <= a_i;
      hi_q    <= '0;
      lo_q    <= b_i;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else if (state_q == RUN) begin
      {hi_q, lo_q} <= acc_d;
      cnt_q        <= cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        state_q <= DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
        prod_q  <= acc_d;
      end
    end else begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end
  end
  // ALU operands are forced to zero outside RUN so the owning datapath can use the ALU.
  assign alu_src1_o = busy_q ? hi_q : '0;
  assign alu_src2_o = (busy_q && lo_q[0]) ? mcand_q : '0;
  assign alu_ctrl_o = ALU_CTRL_ADD;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign prod_o     = prod_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: directed and random product checks of alu_mul_seq against a behavioural ALU adder.
module tb_alu_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        busy_o, done_o;
  logic [63:0] prod_o;
  logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
  logic [3:0]  alu_ctrl_o;
  logic        alu_cout_i;
  int          checks = 0, failures = 0;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .a_i(a_i), .b_i(b_i),
    .busy_o(busy_o), .done_o(done_o), .prod_o(prod_o),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .alu_result_i(alu_result_i), .alu_cout_i(alu_cout_i)
  );

  assign {alu_cout_i, alu_result_i} = {1'b0, alu_src1_o} + {1'b0, alu_src2_o};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
      chk("alu_ctrl", 64'(alu_ctrl_o), 64'h2);
    end
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp, input string tag);
    int n;
    start_i = 1'b1; a_i = a; b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom;
    chk({tag, "_busy"}, 64'(busy_o), 64'd1);
    wait_done(n);
    chk({tag, "_lat"}, 64'(n), 64'd32);
    chk({tag, "_prod"}, prod_o, exp);
    chk({tag, "_busy_done"}, 64'(busy_o), 64'd0);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    #1;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_prod", prod_o, 64'd0);
    chk("rst_src1", 64'(alu_src1_o), 64'd0);
    chk("rst_src2", 64'(alu_src2_o), 64'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    mul(32'd3, 32'd5, 64'h0F, "t1");
    @(posedge clk); #1;
    chk("t1_pulse", 64'(done_o), 64'd0);
    chk("t1_hold", prod_o, 64'h0F);
    chk("idle_src1", 64'(alu_src1_o), 64'd0);
    chk("idle_src2", 64'(alu_src2_o), 64'd0);

    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "t2");
    mul(32'd0, 32'h1234_5678, 64'd0, "t3a");
    mul(32'h8000_0000, 32'd2, 64'h1_0000_0000, "t3b");

    start_i = 1'b1; a_i = 32'd3; b_i = 32'd5;
    @(posedge clk); #1;
    a_i = 32'd7; b_i = 32'd9;
    wait_done(n);
    chk("t4_lat", 64'(n), 64'd32);
    chk("t4_prod", prod_o, 64'h0F);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("t4_rebusy", 64'(busy_o), 64'd1);
    chk("t4_prod_kept", prod_o, 64'h0F);
    wait_done(n);
    chk("t4_b2b_lat", 64'(n + 1), 64'd33);
    chk("t4_prod2", prod_o, 64'h3F);

    start_i = 1'b1; a_i = 32'd6; b_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t5_busy", 64'(busy_o), 64'd0);
    chk("t5_done", 64'(done_o), 64'd0);
    chk("t5_prod", prod_o, 64'd0);
    chk("t5_src1", 64'(alu_src1_o), 64'd0);
    repeat (3) begin
      @(posedge clk); #1;
      chk("t5_nodone", 64'(done_o), 64'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    mul(32'd11, 32'd13, 64'd143, "t5_post");

    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      ra = $urandom; rb = $urandom;
      mul(ra, rb, {32'd0, ra} * {32'd0, rb}, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
